mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single downstream memory port (cache-style rd/wr interface to the AXI bridge) between the instruction side (cache_select_im output) and the data side (cache_select_dm output).
- Arbitrates reads between IF and MEM, forwards MEM writes, and routes returned beats back to the read owner.
- Blocks MEM reads while a MEM write is outstanding, so a load can never overtake a store.
- Sits between the two cache-select muxes and the bus bridge.

Parameters:
LINE_W, 128, write data width in bits (one cache line of 4 words)

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
IF_rd_req  in  1  instruction-side read request
IF_rd_type  in  3  read type (000 byte, 001 half, 010 word, 100 line)
IF_rd_addr  in  32  read physical address
IF_rd_rdy  out  1  IF request accepted this cycle
IF_ret_valid  out  1  returned beat valid for IF
IF_ret_last  out  1  last returned beat for IF
MEM_rd_req  in  1  data-side read request
MEM_rd_type  in  3  read type
MEM_rd_addr  in  32  read physical address
MEM_rd_rdy  out  1  MEM read accepted this cycle
MEM_ret_valid  out  1  returned beat valid for MEM
MEM_ret_last  out  1  last returned beat for MEM
ret_data_out  out  32  returned beat data, shared by both requesters
MEM_wr_req  in  1  data-side write request
MEM_wr_type  in  3  write type
MEM_wr_addr  in  32  write address
MEM_wr_wstrb  in  4  byte strobe
MEM_wr_data  in  LINE_W  write data
MEM_wr_rdy  out  1  write accepted this cycle
rd_req  out  1  downstream read request
rd_type  out  3  downstream read type
rd_addr  out  32  downstream read address
rd_rdy  in  1  downstream read accepted
ret_valid  in  1  downstream returned beat valid
ret_last  in  1  downstream last beat
ret_data  in  32  downstream beat data
wr_req  out  1  downstream write request
wr_type  out  3  downstream write type
wr_addr  out  32  downstream write address
wr_wstrb  out  4  downstream byte strobe
wr_data  out  LINE_W  downstream write data
wr_rdy  in  1  downstream write accepted
wr_done  in  1  downstream write response (B channel) received

Behaviour:
- One clock, clk. resetn is asynchronous and active-low. All state and registered outputs clear on reset: both FSMs return to IDLE, owner=IF, last_grant=IF, rd_req=0, wr_req=0, all type/addr/wstrb/data registers=0.
- Read FSM: R_IDLE -> R_REQ -> R_WAIT -> R_IDLE.
  - R_IDLE, candidates are IF_rd_req and (MEM_rd_req and write FSM in W_IDLE and no MEM_wr_req this cycle).
  - One candidate: grant it. Both: grant the one not equal to last_grant (round robin).
  - Grant asserts the matching *_rd_rdy combinationally in that cycle. type/addr are latched, owner and last_grant are set, and the FSM moves to R_REQ.
  - *_rd_rdy is 0 in every non-IDLE state.
  - R_REQ: rd_req=1 with the latched type/addr, held stable until rd_rdy=1, then go to R_WAIT. rd_req is registered, so there is 1 cycle from grant to rd_req.
  - R_WAIT: ret_valid is routed to the owner's ret_valid/ret_last (the other requester sees 0); ret_data_out=ret_data combinationally. On ret_valid & ret_last, go to R_IDLE. A new grant is possible in the next cycle.
  - ret_valid outside R_WAIT is ignored; both ret_valid outputs stay 0.
- Write FSM: W_IDLE -> W_REQ -> W_WAIT -> W_IDLE.
  - W_IDLE: MEM_wr_req -> MEM_wr_rdy=1 combinationally; latch type/addr/wstrb/data; go to W_REQ.
  - W_REQ: wr_req=1, stable until wr_rdy=1, then go to W_WAIT.
  - W_WAIT: wait for wr_done=1, then go to W_IDLE. MEM_wr_rdy=0 outside W_IDLE.
- Ordering:
  - MEM read and MEM write requested in the same cycle: the write is accepted and the read is not granted.
  - MEM read is never granted while the write FSM is not in W_IDLE.
  - IF reads may proceed during an outstanding write.
- wr_done or rd_rdy arriving in an unexpected state: ignored.
- Reset mid-transaction: both FSMs abort to IDLE immediately; the downstream bridge is reset by the same resetn.

Decomposition:
- Shared package or header (MacroDef): read-FSM state codes (R_IDLE=2'd0, R_REQ=2'd1, R_WAIT=2'd2), write-FSM state codes (W_IDLE, W_REQ, W_WAIT), owner codes (OWN_IF=1'b0, OWN_MEM=1'b1), rd_type encodings.
- Natural sub-module: mem_wr_channel (write FSM plus latch), exporting wr_busy to the read arbiter.

Test Plan:
- IF_rd_req only, type 100, addr 0x1fc00000; rd_rdy after 2 cycles; 4 beats 0x11..0x44 with last on beat 4 -> IF_rd_rdy for 1 cycle, rd_req one cycle later and held 2 cycles, IF_ret_valid x4, IF_ret_last on beat 4, MEM_ret_valid stays 0.
- IF and MEM read together, repeated 4 times, last_grant=IF after reset -> grants alternate MEM, IF, MEM, IF.
- MEM_wr_req addr 0x00001000 wstrb 0xF; wr_done delayed 5 cycles; MEM_rd_req from the next cycle -> MEM_rd_rdy=0 until the cycle after wr_done, then granted.
- Same-cycle MEM_wr_req and MEM_rd_req -> MEM_wr_rdy=1, MEM_rd_rdy=0; read granted only after wr_done.
- IF read during an outstanding write -> IF granted and completes while the write FSM sits in W_WAIT.
- resetn pulled low during R_WAIT after beat 2 -> rd_req=0 and wr_req=0 immediately, FSMs in IDLE; a new IF request after release is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared state, owner and request-type codes for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    RIdle = 2'd0,
    RReq  = 2'd1,
    RWait = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WIdle = 2'd0,
    WReq  = 2'd1,
    WWait = 2'd2
  } wr_state_e;

  typedef enum logic {
    OwnIf  = 1'b0,
    OwnMem = 1'b1
  } owner_e;

  localparam logic [2:0] RdTypeByte = 3'b000;
  localparam logic [2:0] RdTypeHalf = 3'b001;
  localparam logic [2:0] RdTypeWord = 3'b010;
  localparam logic [2:0] RdTypeLine = 3'b100;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of upstream (IF/MEM) and downstream (bridge) signals around the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned LINE_W = 128
);
  logic              IF_rd_req;
  logic [2:0]        IF_rd_type;
  logic [31:0]       IF_rd_addr;
  logic              IF_rd_rdy;
  logic              IF_ret_valid;
  logic              IF_ret_last;
  logic              MEM_rd_req;
  logic [2:0]        MEM_rd_type;
  logic [31:0]       MEM_rd_addr;
  logic              MEM_rd_rdy;
  logic              MEM_ret_valid;
  logic              MEM_ret_last;
  logic [31:0]       ret_data_out;
  logic              MEM_wr_req;
  logic [2:0]        MEM_wr_type;
  logic [31:0]       MEM_wr_addr;
  logic [3:0]        MEM_wr_wstrb;
  logic [LINE_W-1:0] MEM_wr_data;
  logic              MEM_wr_rdy;
  logic              rd_req;
  logic [2:0]        rd_type;
  logic [31:0]       rd_addr;
  logic              rd_rdy;
  logic              ret_valid;
  logic              ret_last;
  logic [31:0]       ret_data;
  logic              wr_req;
  logic [2:0]        wr_type;
  logic [31:0]       wr_addr;
  logic [3:0]        wr_wstrb;
  logic [LINE_W-1:0] wr_data;
  logic              wr_rdy;
  logic              wr_done;

  // Arbiter view.
  modport slave (
    input  IF_rd_req, IF_rd_type, IF_rd_addr,
    output IF_rd_rdy, IF_ret_valid, IF_ret_last,
    input  MEM_rd_req, MEM_rd_type, MEM_rd_addr,
    output MEM_rd_rdy, MEM_ret_valid, MEM_ret_last, ret_data_out,
    input  MEM_wr_req, MEM_wr_type, MEM_wr_addr, MEM_wr_wstrb, MEM_wr_data,
    output MEM_wr_rdy,
    output rd_req, rd_type, rd_addr,
    input  rd_rdy, ret_valid, ret_last, ret_data,
    output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  wr_rdy, wr_done
  );

  // Environment view: requesters plus bus bridge.
  modport master (
    output IF_rd_req, IF_rd_type, IF_rd_addr,
    input  IF_rd_rdy, IF_ret_valid, IF_ret_last,
    output MEM_rd_req, MEM_rd_type, MEM_rd_addr,
    input  MEM_rd_rdy, MEM_ret_valid, MEM_ret_last, ret_data_out,
    output MEM_wr_req, MEM_wr_type, MEM_wr_addr, MEM_wr_wstrb, MEM_wr_data,
    input  MEM_wr_rdy,
    input  rd_req, rd_type, rd_addr,
    output rd_rdy, ret_valid, ret_last, ret_data,
    input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output wr_rdy, wr_done
  );
endinterface

// File: rtl/mem_port_arbiter_wr_channel.sv
// Data-side write channel: accepts one write, presents it downstream, waits for the response.
module mem_port_arbiter_wr_channel
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_wr_req,
  input  logic [2:0]        mem_wr_type,
  input  logic [31:0]       mem_wr_addr,
  input  logic [3:0]        mem_wr_wstrb,
  input  logic [LINE_W-1:0] mem_wr_data,
  output logic              mem_wr_rdy,
  output logic              wr_req,
  output logic [2:0]        wr_type,
  output logic [31:0]       wr_addr,
  output logic [3:0]        wr_wstrb,
  output logic [LINE_W-1:0] wr_data,
  input  logic              wr_rdy,
  input  logic              wr_done,
  output logic              wr_busy
);

  wr_state_e state_q;

  assign mem_wr_rdy = (state_q == WIdle) && mem_wr_req;
  assign wr_busy    = (state_q != WIdle);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= WIdle;
      wr_req   <= 1'b0;
      wr_type  <= '0;
      wr_addr  <= '0;
      wr_wstrb <= '0;
      wr_data  <= '0;
    end else begin
      unique case (state_q)
        WIdle: begin
          if (mem_wr_req) begin
            wr_type  <= mem_wr_type;
            wr_addr  <= mem_wr_addr;
            wr_wstrb <= mem_wr_wstrb;
            wr_data  <= mem_wr_data;
            wr_req   <= 1'b1;
            state_q  <= WReq;
          end
        end
        WReq: begin
          if (wr_rdy) begin
            wr_req  <= 1'b0;
            state_q <= WWait;
          end
        end
        WWait: begin
          if (wr_done) state_q <= WIdle;
        end
        default: begin
          wr_req  <= 1'b0;
          state_q <= WIdle;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction reads and data reads/writes.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LINE_W = 128
) (
  input logic              clk,
  input logic              resetn,
  mem_port_arbiter_if.slave bus
);

  rd_state_e   state_q;
  owner_e      owner_q;
  owner_e      last_grant_q;
  logic        rd_req_q;
  logic [2:0]  rd_type_q;
  logic [31:0] rd_addr_q;
  logic        wr_busy;
  logic        if_cand;
  logic        mem_cand;
  logic        grant_if;
  logic        grant_mem;
  logic        in_wait;

  // A pending or same-cycle store keeps data-side loads out so they cannot overtake it.
  assign if_cand   = (state_q == RIdle) && bus.IF_rd_req;
  assign mem_cand  = (state_q == RIdle) && bus.MEM_rd_req && !wr_busy && !bus.MEM_wr_req;
  assign grant_if  = if_cand && (!mem_cand || (last_grant_q == OwnMem));
  assign grant_mem = mem_cand && (!if_cand || (last_grant_q == OwnIf));

  assign bus.IF_rd_rdy  = grant_if;
  assign bus.MEM_rd_rdy = grant_mem;

  assign in_wait           = (state_q == RWait) && bus.ret_valid;
  assign bus.IF_ret_valid  = in_wait && (owner_q == OwnIf);
  assign bus.IF_ret_last   = in_wait && (owner_q == OwnIf) && bus.ret_last;
  assign bus.MEM_ret_valid = in_wait && (owner_q == OwnMem);
  assign bus.MEM_ret_last  = in_wait && (owner_q == OwnMem) && bus.ret_last;
  assign bus.ret_data_out  = bus.ret_data;

  assign bus.rd_req  = rd_req_q;
  assign bus.rd_type = rd_type_q;
  assign bus.rd_addr = rd_addr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= RIdle;
      owner_q      <= OwnIf;
      last_grant_q <= OwnIf;
      rd_req_q     <= 1'b0;
      rd_type_q    <= '0;
      rd_addr_q    <= '0;
    end else begin
      unique case (state_q)
        RIdle: begin
          if (grant_if || grant_mem) begin
            owner_q      <= grant_mem ? OwnMem : OwnIf;
            last_grant_q <= grant_mem ? OwnMem : OwnIf;
            rd_type_q    <= grant_mem ? bus.MEM_rd_type : bus.IF_rd_type;
            rd_addr_q    <= grant_mem ? bus.MEM_rd_addr : bus.IF_rd_addr;
            rd_req_q     <= 1'b1;
            state_q      <= RReq;
          end
        end
        RReq: begin
          if (bus.rd_rdy) begin
            rd_req_q <= 1'b0;
            state_q  <= RWait;
          end
        end
        RWait: begin
          if (bus.ret_valid && bus.ret_last) state_q <= RIdle;
        end
        default: begin
          rd_req_q <= 1'b0;
          state_q  <= RIdle;
        end
      endcase
    end
  end

  mem_port_arbiter_wr_channel #(
    .LINE_W (LINE_W)
  ) u_wr_channel (
    .clk          (clk),
    .resetn       (resetn),
    .mem_wr_req   (bus.MEM_wr_req),
    .mem_wr_type  (bus.MEM_wr_type),
    .mem_wr_addr  (bus.MEM_wr_addr),
    .mem_wr_wstrb (bus.MEM_wr_wstrb),
    .mem_wr_data  (bus.MEM_wr_data),
    .mem_wr_rdy   (bus.MEM_wr_rdy),
    .wr_req       (bus.wr_req),
    .wr_type      (bus.wr_type),
    .wr_addr      (bus.wr_addr),
    .wr_wstrb     (bus.wr_wstrb),
    .wr_data      (bus.wr_data),
    .wr_rdy       (bus.wr_rdy),
    .wr_done      (bus.wr_done),
    .wr_busy      (wr_busy)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: requesters and bridge driven with $urandom, checked against a transaction model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.LINE_W(128)) bus ();

  mem_port_arbiter #(.LINE_W(128)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // At most one read and one write can be in flight at a time.
  typedef struct {
    bit          valid;
    bit          acked;
    bit          own_mem;
    logic [2:0]  typ;
    logic [31:0] addr;
  } rd_txn_t;

  typedef struct {
    bit           valid;
    bit           acked;
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wr_txn_t;

  rd_txn_t rd;
  wr_txn_t wr;
  bit      last_mem;
  bit      g_if;
  bit      g_mem;
  logic [2:0] type_tab [4];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rd = '{default: '0};
    wr = '{default: '0};
    last_mem = 1'b0;
  endtask

  task automatic drive_random();
    bus.IF_rd_req    = 1'($urandom_range(0, 1));
    bus.IF_rd_type   = type_tab[$urandom_range(0, 3)];
    bus.IF_rd_addr   = $urandom;
    bus.MEM_rd_req   = 1'($urandom_range(0, 1));
    bus.MEM_rd_type  = type_tab[$urandom_range(0, 3)];
    bus.MEM_rd_addr  = $urandom;
    bus.MEM_wr_req   = ($urandom_range(0, 3) == 0);
    bus.MEM_wr_type  = 3'($urandom);
    bus.MEM_wr_addr  = $urandom;
    bus.MEM_wr_wstrb = 4'($urandom);
    bus.MEM_wr_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.rd_rdy       = 1'($urandom_range(0, 1));
    bus.ret_valid    = 1'($urandom_range(0, 1));
    bus.ret_last     = ($urandom_range(0, 2) == 0);
    bus.ret_data     = $urandom;
    bus.wr_rdy       = 1'($urandom_range(0, 1));
    bus.wr_done      = ($urandom_range(0, 2) == 0);
  endtask

  task automatic drive_idle();
    bus.IF_rd_req = 0; bus.IF_rd_type = 0; bus.IF_rd_addr = 0;
    bus.MEM_rd_req = 0; bus.MEM_rd_type = 0; bus.MEM_rd_addr = 0;
    bus.MEM_wr_req = 0; bus.MEM_wr_type = 0; bus.MEM_wr_addr = 0;
    bus.MEM_wr_wstrb = 0; bus.MEM_wr_data = 0;
    bus.rd_rdy = 0; bus.ret_valid = 0; bus.ret_last = 0; bus.ret_data = 0;
    bus.wr_rdy = 0; bus.wr_done = 0;
  endtask

  task automatic check_outputs();
    bit if_c, mem_c, beat;
    if_c  = !rd.valid && bus.IF_rd_req;
    mem_c = !rd.valid && bus.MEM_rd_req && !wr.valid && !bus.MEM_wr_req;
    g_if  = if_c && (!mem_c || last_mem);
    g_mem = mem_c && (!if_c || !last_mem);
    beat  = rd.valid && rd.acked && bus.ret_valid;
    check_val("if_rd_rdy", 128'(bus.IF_rd_rdy), 128'(g_if));
    check_val("mem_rd_rdy", 128'(bus.MEM_rd_rdy), 128'(g_mem));
    check_val("mem_wr_rdy", 128'(bus.MEM_wr_rdy), 128'(!wr.valid && bus.MEM_wr_req));
    check_val("if_ret_valid", 128'(bus.IF_ret_valid), 128'(beat && !rd.own_mem));
    check_val("if_ret_last", 128'(bus.IF_ret_last), 128'(beat && !rd.own_mem && bus.ret_last));
    check_val("mem_ret_valid", 128'(bus.MEM_ret_valid), 128'(beat && rd.own_mem));
    check_val("mem_ret_last", 128'(bus.MEM_ret_last), 128'(beat && rd.own_mem && bus.ret_last));
    check_val("ret_data_out", 128'(bus.ret_data_out), 128'(bus.ret_data));
    check_val("rd_req", 128'(bus.rd_req), 128'(rd.valid && !rd.acked));
    if (rd.valid && !rd.acked) begin
      check_val("rd_type", 128'(bus.rd_type), 128'(rd.typ));
      check_val("rd_addr", 128'(bus.rd_addr), 128'(rd.addr));
    end
    check_val("wr_req", 128'(bus.wr_req), 128'(wr.valid && !wr.acked));
    if (wr.valid && !wr.acked) begin
      check_val("wr_type", 128'(bus.wr_type), 128'(wr.typ));
      check_val("wr_addr", 128'(bus.wr_addr), 128'(wr.addr));
      check_val("wr_wstrb", 128'(bus.wr_wstrb), 128'(wr.wstrb));
      check_val("wr_data", bus.wr_data, wr.data);
    end
  endtask

  task automatic step_model();
    if (rd.valid) begin
      if (!rd.acked) begin
        if (bus.rd_rdy) rd.acked = 1'b1;
      end else if (bus.ret_valid && bus.ret_last) begin
        rd.valid = 1'b0;
      end
    end else if (g_if || g_mem) begin
      rd.valid   = 1'b1;
      rd.acked   = 1'b0;
      rd.own_mem = g_mem;
      rd.typ     = g_mem ? bus.MEM_rd_type : bus.IF_rd_type;
      rd.addr    = g_mem ? bus.MEM_rd_addr : bus.IF_rd_addr;
      last_mem   = g_mem;
    end
    if (wr.valid) begin
      if (!wr.acked) begin
        if (bus.wr_rdy) wr.acked = 1'b1;
      end else if (bus.wr_done) begin
        wr.valid = 1'b0;
      end
    end else if (bus.MEM_wr_req) begin
      wr.valid = 1'b1;
      wr.acked = 1'b0;
      wr.typ   = bus.MEM_wr_type;
      wr.addr  = bus.MEM_wr_addr;
      wr.wstrb = bus.MEM_wr_wstrb;
      wr.data  = bus.MEM_wr_data;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    drive_random();
    #1;
    check_outputs();
    @(posedge clk);
    step_model();
  endtask

  initial begin
    bit reached;
    type_tab[0] = 3'b000;
    type_tab[1] = 3'b001;
    type_tab[2] = 3'b010;
    type_tab[3] = 3'b100;
    drive_idle();
    model_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_rd_req", 128'(bus.rd_req), 128'(0));
    check_val("rst_wr_req", 128'(bus.wr_req), 128'(0));
    check_val("rst_rd_addr", 128'(bus.rd_addr), 128'(0));
    check_val("rst_rd_type", 128'(bus.rd_type), 128'(0));
    check_val("rst_wr_addr", 128'(bus.wr_addr), 128'(0));
    check_val("rst_wr_data", bus.wr_data, 128'(0));
    resetn = 1'b1;

    repeat (1500) run_cycle();

    // Push a read into its return phase, then reset asynchronously between edges.
    reached = 1'b0;
    for (int i = 0; i < 300 && !reached; i++) begin
      run_cycle();
      reached = rd.valid && rd.acked;
    end
    check_val("reach_rd_wait", 128'(reached), 128'(1));
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_val("midrst_rd_req", 128'(bus.rd_req), 128'(0));
    check_val("midrst_wr_req", 128'(bus.wr_req), 128'(0));
    check_val("midrst_rd_addr", 128'(bus.rd_addr), 128'(0));
    check_val("midrst_wr_data", bus.wr_data, 128'(0));
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    model_reset();
    resetn = 1'b1;

    repeat (1500) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
